mmio_port_bridge: RTL and testbench

//   Device-side endpoint for one MMIO port pair (even = data, odd = cmd/status).
//   CPU stores to the port registers become TX FIFO pushes toward an external

---
 rtl/mmio_port_bridge.sv | 125 ++++++++++++
 tb/tb_mmio_port_bridge.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_port_bridge.sv
// MMIO port-pair endpoint: toggle-coded commands on the odd word drive a TX FIFO
// toward a valid/ready sink, and pop an RX FIFO filled by a valid/ready source.
module mmio_port_bridge #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_word,
  input  logic [15:0] cmd_word,
  output logic [15:0] rd_data,
  output logic [15:0] status,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  output logic        rx_ready
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [4:0]      DEPTH_C = 5'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C = PTR_W'(FIFO_DEPTH - 1);

  // Wrap by compare so depths that are not a power of two work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  logic [15:0] tx_mem [0:FIFO_DEPTH-1];
  logic [15:0] rx_mem [0:FIFO_DEPTH-1];

  logic [2:0]       cmd_prev_q;
  logic [PTR_W-1:0] tx_head_q, tx_head_d, tx_tail_q, tx_tail_d;
  logic [PTR_W-1:0] rx_head_q, rx_head_d, rx_tail_q, rx_tail_d;
  logic [4:0]       tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic             tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
  logic             push_ack_q, push_ack_d, pop_ack_q, pop_ack_d;

  logic [2:0] evt;
  logic       clear_evt, tx_push, tx_pop, tx_reject, rx_fill, rx_pop, rx_reject;
  logic       unused_cmd_bits;

  assign unused_cmd_bits = ^cmd_word[15:3];

  assign evt       = cmd_word[2:0] ^ cmd_prev_q;
  assign clear_evt = evt[2];

  assign tx_valid = (tx_count_q != 5'd0);
  assign tx_data  = tx_valid ? tx_mem[tx_head_q] : 16'h0000;
  assign rx_ready = (rx_count_q < DEPTH_C);
  assign rd_data  = (rx_count_q != 5'd0) ? rx_mem[rx_head_q] : 16'h0000;

  // Full/empty decisions use the pre-edge counts, so a same-cycle drain or
  // fill never rescues a push into a full TX FIFO or a pop from an empty RX FIFO.
  assign tx_push   = evt[0] & ~clear_evt & (tx_count_q < DEPTH_C);
  assign tx_reject = evt[0] & ~clear_evt & (tx_count_q >= DEPTH_C);
  assign tx_pop    = tx_valid & tx_ready & ~clear_evt;
  assign rx_fill   = rx_valid & rx_ready & ~clear_evt;
  assign rx_pop    = evt[1] & ~clear_evt & (rx_count_q != 5'd0);
  assign rx_reject = evt[1] & ~clear_evt & (rx_count_q == 5'd0);

  assign status = {pop_ack_q, push_ack_q, rx_udf_q, tx_ovf_q,
                   (rx_count_q != 5'd0), (tx_count_q == DEPTH_C),
                   rx_count_q, tx_count_q};

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves a variable unassigned, which would infer a latch.
    tx_head_d  = tx_pop  ? ptr_inc(tx_head_q) : tx_head_q;
    tx_tail_d  = tx_push ? ptr_inc(tx_tail_q) : tx_tail_q;
    rx_head_d  = rx_pop  ? ptr_inc(rx_head_q) : rx_head_q;
    rx_tail_d  = rx_fill ? ptr_inc(rx_tail_q) : rx_tail_q;
    tx_count_d = tx_count_q + 5'(tx_push) - 5'(tx_pop);
    rx_count_d = rx_count_q + 5'(rx_fill) - 5'(rx_pop);
    tx_ovf_d   = tx_ovf_q | tx_reject;
    rx_udf_d   = rx_udf_q | rx_reject;
    push_ack_d = tx_push ? cmd_word[0] : push_ack_q;
    pop_ack_d  = rx_pop  ? cmd_word[1] : pop_ack_q;
    if (clear_evt) begin
      tx_head_d  = '0;
      tx_tail_d  = '0;
      rx_head_d  = '0;
      rx_tail_d  = '0;
      tx_count_d = '0;
      rx_count_d = '0;
      tx_ovf_d   = 1'b0;
      rx_udf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      cmd_prev_q <= '0;
      tx_head_q  <= '0;
      tx_tail_q  <= '0;
      rx_head_q  <= '0;
      rx_tail_q  <= '0;
      tx_count_q <= '0;
      rx_count_q <= '0;
      tx_ovf_q   <= 1'b0;
      rx_udf_q   <= 1'b0;
      push_ack_q <= 1'b0;
      pop_ack_q  <= 1'b0;
    end else begin
      cmd_prev_q <= cmd_word[2:0];
      tx_head_q  <= tx_head_d;
      tx_tail_q  <= tx_tail_d;
      rx_head_q  <= rx_head_d;
      rx_tail_q  <= rx_tail_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_udf_q   <= rx_udf_d;
      push_ack_q <= push_ack_d;
      pop_ack_q  <= pop_ack_d;
    end
  end

  // NOTE: storage arrays are not reset; zero counts make stale entries invisible.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_tail_q] <= data_word;
    if (rx_fill) rx_mem[rx_tail_q] <= rx_data;
  end

endmodule

// File: tb/tb_mmio_port_bridge.sv
// Directed bench for mmio_port_bridge: a vector table for single-cycle behaviour
// plus hand sequences for fill/overflow, same-cycle full push, wrap and reset.
module tb_mmio_port_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_word, cmd_word, rx_data;
  logic        tx_ready, rx_valid;

  logic [15:0] rd_data8, status8, tx_data8, rd_data5, status5, tx_data5;
  logic        tx_valid8, rx_ready8, tx_valid5, rx_ready5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mmio_port_bridge #(.FIFO_DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .data_word(data_word), .cmd_word(cmd_word),
    .rd_data(rd_data8), .status(status8), .tx_valid(tx_valid8), .tx_data(tx_data8),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready8)
  );

  mmio_port_bridge #(.FIFO_DEPTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .data_word(data_word), .cmd_word(cmd_word),
    .rd_data(rd_data5), .status(status5), .tx_valid(tx_valid5), .tx_data(tx_data5),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready5)
  );

  typedef struct {
    logic [15:0] dw;
    logic [15:0] cmd;
    logic        trdy;
    logic        rxv;
    logic [15:0] rxd;
    logic [15:0] st;
    logic        tv;
    logic [15:0] td;
    logic [15:0] rd;
    logic        rr;
  } vec_t;

  vec_t vecs[21];

  // Status word for the depth-8 instance from hand-computed field values.
  function automatic logic [15:0] st(input bit pa, input bit pu, input bit un, input bit ov,
                                     input int rxc, input int txc);
    return {pa, pu, un, ov, (rxc != 0), (txc == 8), 5'(rxc), 5'(txc)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Post-reset table: cmd is the absolute cmd_word value for that cycle.
    vecs[0]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, st(0,0,0,0,1,0), 1'b0, 16'h0000, 16'h0001, 1'b1};
    vecs[1]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0002, st(0,0,0,0,2,0), 1'b0, 16'h0000, 16'h0001, 1'b1};
    vecs[2]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0003, st(0,0,0,0,3,0), 1'b0, 16'h0000, 16'h0001, 1'b1};
    vecs[3]  = '{16'h0000, 16'h0002, 1'b0, 1'b0, 16'h0000, st(1,0,0,0,2,0), 1'b0, 16'h0000, 16'h0002, 1'b1};
    vecs[4]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, st(0,0,0,0,1,0), 1'b0, 16'h0000, 16'h0003, 1'b1};
    vecs[5]  = '{16'h0000, 16'h0002, 1'b0, 1'b0, 16'h0000, st(1,0,0,0,0,0), 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, st(1,0,1,0,0,0), 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[7]  = '{16'hA5A5, 16'h0001, 1'b0, 1'b0, 16'h0000, st(1,1,1,0,0,1), 1'b1, 16'hA5A5, 16'h0000, 1'b1};
    vecs[8]  = '{16'hA5A5, 16'h0001, 1'b1, 1'b0, 16'h0000, st(1,1,1,0,0,0), 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[9]  = '{16'hA5A5, 16'h0001, 1'b0, 1'b0, 16'h0000, st(1,1,1,0,0,0), 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[10] = '{16'h1234, 16'h0000, 1'b0, 1'b1, 16'h0055, st(1,0,1,0,1,1), 1'b1, 16'h1234, 16'h0055, 1'b1};
    vecs[11] = '{16'hBEEF, 16'h0005, 1'b1, 1'b1, 16'h0077, st(1,0,0,0,0,0), 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[12] = '{16'hBEEF, 16'h0005, 1'b0, 1'b0, 16'h0000, st(1,0,0,0,0,0), 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[13] = '{16'hC001, 16'h0004, 1'b0, 1'b0, 16'h0000, st(1,0,0,0,0,1), 1'b1, 16'hC001, 16'h0000, 1'b1};
    vecs[14] = '{16'hC002, 16'h0005, 1'b1, 1'b0, 16'h0000, st(1,1,0,0,0,1), 1'b1, 16'hC002, 16'h0000, 1'b1};
    vecs[15] = '{16'hC002, 16'h0005, 1'b1, 1'b1, 16'h00A1, st(1,1,0,0,1,0), 1'b0, 16'h0000, 16'h00A1, 1'b1};
    vecs[16] = '{16'hC002, 16'h0007, 1'b0, 1'b1, 16'h00A2, st(1,1,0,0,1,0), 1'b0, 16'h0000, 16'h00A2, 1'b1};
    vecs[17] = '{16'hC002, 16'h0007, 1'b0, 1'b0, 16'h0000, st(1,1,0,0,1,0), 1'b0, 16'h0000, 16'h00A2, 1'b1};
    vecs[18] = '{16'hC002, 16'h0005, 1'b0, 1'b0, 16'h0000, st(0,1,0,0,0,0), 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[19] = '{16'hC002, 16'h0007, 1'b0, 1'b1, 16'h00A3, st(0,1,1,0,1,0), 1'b0, 16'h0000, 16'h00A3, 1'b1};
    vecs[20] = '{16'hC002, 16'h0007, 1'b0, 1'b0, 16'h0000, st(0,1,1,0,1,0), 1'b0, 16'h0000, 16'h00A3, 1'b1};

    // Reset held while the source offers data and the sink stalls.
    rst_n     = 1'b0;
    data_word = 16'h0000;
    cmd_word  = 16'h0000;
    tx_ready  = 1'b0;
    rx_valid  = 1'b1;
    rx_data   = 16'hDEAD;
    repeat (3) step();
    check("reset status",   status8,   16'h0000);
    check("reset rx_ready", rx_ready8, 1'b1);
    check("reset tx_valid", tx_valid8, 1'b0);
    check("reset tx_data",  tx_data8,  16'h0000);
    check("reset rd_data",  rd_data8,  16'h0000);
    check("reset status d5", status5,  16'h0000);

    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      data_word = vecs[i].dw;
      cmd_word  = vecs[i].cmd;
      tx_ready  = vecs[i].trdy;
      rx_valid  = vecs[i].rxv;
      rx_data   = vecs[i].rxd;
      step();
      check($sformatf("vec%0d status", i),    status8,   vecs[i].st);
      check($sformatf("vec%0d tx_valid", i),  tx_valid8, vecs[i].tv);
      check($sformatf("vec%0d tx_data", i),   tx_data8,  vecs[i].td);
      check($sformatf("vec%0d rd_data", i),   rd_data8,  vecs[i].rd);
      check($sformatf("vec%0d rx_ready", i),  rx_ready8, vecs[i].rr);
      check($sformatf("vec%0d status d5", i), status5,   vecs[i].st);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b0;

    // Nine pushes into an 8-deep FIFO with the sink stalled.
    cmd_word[2] = ~cmd_word[2];
    step();
    check("clear before fill", status8, st(0,1,0,0,0,0));
    for (int i = 0; i < 9; i++) begin
      data_word   = 16'h0100 + 16'(i);
      cmd_word[0] = ~cmd_word[0];
      step();
      if (i == 7) check("eighth push status", status8, st(0,1,0,0,0,8));
    end
    check("ninth push status", status8, st(0,1,0,1,0,8));
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain order %0d", i), tx_data8, 32'h0100 + 32'(i));
      step();
    end
    check("drained tx_valid", tx_valid8, 1'b0);
    tx_ready = 1'b0;

    // Push into a full FIFO while the sink drains in the same cycle.
    cmd_word[2] = ~cmd_word[2];
    step();
    for (int i = 0; i < 8; i++) begin
      data_word   = 16'h0200 + 16'(i);
      cmd_word[0] = ~cmd_word[0];
      step();
    end
    check("refill flags", status8[12:10], 3'b001);
    data_word   = 16'h02FF;
    tx_ready    = 1'b1;
    cmd_word[0] = ~cmd_word[0];
    step();
    tx_ready = 1'b0;
    check("full push count", status8[4:0], 5'd7);
    check("full push ovf",   status8[12],  1'b1);
    check("full push head",  tx_data8,     16'h0201);

    // Depth-5 pointer wrap on both FIFOs.
    cmd_word[2] = ~cmd_word[2];
    step();
    check("d5 clear status", status5[13:0], 14'h0000);
    for (int i = 0; i < 3; i++) begin
      data_word   = 16'h0500 + 16'(i);
      cmd_word[0] = ~cmd_word[0];
      step();
    end
    tx_ready = 1'b1;
    repeat (3) step();
    tx_ready = 1'b0;
    check("d5 pre-wrap empty", tx_valid5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      data_word   = 16'h0600 + 16'(i);
      cmd_word[0] = ~cmd_word[0];
      step();
      if (i == 4) check("d5 full no ovf", status5[12:10], 3'b001);
    end
    check("d5 count after 6", status5[4:0], 5'd5);
    check("d5 overflow",      status5[12],  1'b1);
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("d5 tx wrap %0d", i), tx_data5, 32'h0600 + 32'(i));
      step();
    end
    tx_ready = 1'b0;
    check("d5 tx drained", tx_valid5, 1'b0);

    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 16'h0700 + 16'(i);
      step();
    end
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_word[1] = ~cmd_word[1];
      step();
    end
    check("d5 rx emptied", rd_data5, 16'h0000);
    rx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_data = 16'h0800 + 16'(i);
      step();
    end
    rx_valid = 1'b0;
    check("d5 rx_ready full", rx_ready5, 1'b0);
    check("d5 rx count",      status5[9:5], 5'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("d5 rx wrap %0d", i), rd_data5, 32'h0800 + 32'(i));
      cmd_word[1] = ~cmd_word[1];
      step();
    end
    check("d5 rx after pops", rd_data5, 16'h0000);

    // Reset mid-operation, released with PUSH already high.
    rst_n     = 1'b0;
    data_word = 16'hD00D;
    cmd_word  = 16'h0001;
    step();
    check("midreset status",   status8,   16'h0000);
    check("midreset tx_valid", tx_valid8, 1'b0);
    rst_n = 1'b1;
    step();
    check("release push valid",  tx_valid8, 1'b1);
    check("release push data",   tx_data8,  16'hD00D);
    check("release push status", status8,   st(0,1,0,0,0,1));
    step();
    check("held cmd no event", status8, st(0,1,0,0,0,1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
